// File: rtl/sensor_frame_scheduler.sv
// Pairs quaternion and gyro updates into frames and publishes them to the MCU-facing
// registers only while the MCU chip select is idle. Also tracks sequence, overruns and staleness.
module sensor_frame_scheduler #(
    parameter int DATA_W       = 16,
    parameter int STALE_CYCLES = 300000,
    parameter int SEQ_W        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_quat_valid,
    input  logic [DATA_W-1:0] in_quat_w,
    input  logic [DATA_W-1:0] in_quat_x,
    input  logic [DATA_W-1:0] in_quat_y,
    input  logic [DATA_W-1:0] in_quat_z,
    input  logic              in_gyro_valid,
    input  logic [DATA_W-1:0] in_gyro_x,
    input  logic [DATA_W-1:0] in_gyro_y,
    input  logic [DATA_W-1:0] in_gyro_z,
    input  logic              mcu_cs_n,
    output logic [DATA_W-1:0] out_quat_w,
    output logic [DATA_W-1:0] out_quat_x,
    output logic [DATA_W-1:0] out_quat_y,
    output logic [DATA_W-1:0] out_quat_z,
    output logic [DATA_W-1:0] out_gyro_x,
    output logic [DATA_W-1:0] out_gyro_y,
    output logic [DATA_W-1:0] out_gyro_z,
    output logic              out_valid,
    output logic [SEQ_W-1:0]  out_seq,
    output logic              stale,
    output logic [7:0]        overrun_cnt
);

    localparam int FRAME_W = 7 * DATA_W;
    localparam int STALE_W = $clog2(STALE_CYCLES + 1);

    typedef enum logic [1:0] {EMPTY, HOLD, PEND} state_t;

    state_t               state_reg, state_next;
    logic                 cs_meta_reg, cs_sync_reg;
    logic                 cs_busy;
    logic [4*DATA_W-1:0]  quat_buf_reg;
    logic [3*DATA_W-1:0]  gyro_buf_reg;
    logic                 q_have_reg, g_have_reg;
    logic [FRAME_W-1:0]   pend_frame_reg;
    logic [FRAME_W-1:0]   out_frame_reg;
    logic                 out_valid_reg;
    logic [SEQ_W-1:0]     out_seq_reg;
    logic [7:0]           overrun_reg;
    logic [STALE_W-1:0]   stale_cnt_reg;

    logic [4*DATA_W-1:0]  quat_cur;
    logic [3*DATA_W-1:0]  gyro_cur;
    logic [FRAME_W-1:0]   frame_cur;
    logic                 q_have_eff, g_have_eff, frame_done;
    logic                 publish_new, publish_pend, load_pend, overrun_inc, publish;

    assign cs_busy = !cs_sync_reg;

    // The frame seen this cycle includes any pulse arriving now (latest wins).
    assign quat_cur   = in_quat_valid ? {in_quat_z, in_quat_y, in_quat_x, in_quat_w} : quat_buf_reg;
    assign gyro_cur   = in_gyro_valid ? {in_gyro_z, in_gyro_y, in_gyro_x} : gyro_buf_reg;
    assign frame_cur  = {gyro_cur, quat_cur};
    assign q_have_eff = q_have_reg | in_quat_valid;
    assign g_have_eff = g_have_reg | in_gyro_valid;
    assign frame_done = q_have_eff & g_have_eff;

    always_comb begin
        state_next   = state_reg;
        publish_new  = 1'b0;
        publish_pend = 1'b0;
        load_pend    = 1'b0;
        overrun_inc  = 1'b0;
        case (state_reg)
            EMPTY, HOLD: begin
                if (frame_done) begin
                    if (cs_busy) begin
                        load_pend  = 1'b1;
                        state_next = PEND;
                    end else begin
                        publish_new = 1'b1;
                        state_next  = HOLD;
                    end
                end
            end
            PEND: begin
                // A fresh frame always displaces the pending one, even on CS release.
                if (frame_done) begin
                    overrun_inc = 1'b1;
                    if (cs_busy) begin
                        load_pend = 1'b1;
                    end else begin
                        publish_new = 1'b1;
                        state_next  = HOLD;
                    end
                end else if (!cs_busy) begin
                    publish_pend = 1'b1;
                    state_next   = HOLD;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    assign publish = publish_new | publish_pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= EMPTY;
            cs_meta_reg    <= 1'b1;
            cs_sync_reg    <= 1'b1;
            quat_buf_reg   <= '0;
            gyro_buf_reg   <= '0;
            q_have_reg     <= 1'b0;
            g_have_reg     <= 1'b0;
            pend_frame_reg <= '0;
            out_frame_reg  <= '0;
            out_valid_reg  <= 1'b0;
            out_seq_reg    <= '0;
            overrun_reg    <= '0;
            stale_cnt_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            cs_meta_reg <= mcu_cs_n;
            cs_sync_reg <= cs_meta_reg;
            if (in_quat_valid) quat_buf_reg <= quat_cur;
            if (in_gyro_valid) gyro_buf_reg <= gyro_cur;
            q_have_reg <= q_have_eff & !frame_done;
            g_have_reg <= g_have_eff & !frame_done;
            if (load_pend) pend_frame_reg <= frame_cur;
            if (publish_new) out_frame_reg <= frame_cur;
            else if (publish_pend) out_frame_reg <= pend_frame_reg;
            if (publish) begin
                out_valid_reg <= 1'b1;
                out_seq_reg   <= out_seq_reg + SEQ_W'(1);
                stale_cnt_reg <= '0;
            end else if (stale_cnt_reg != STALE_W'(STALE_CYCLES)) begin
                stale_cnt_reg <= stale_cnt_reg + STALE_W'(1);
            end
            if (overrun_inc && overrun_reg != 8'hFF) overrun_reg <= overrun_reg + 8'd1;
        end
    end

    logic [DATA_W-1:0] out_field [7];

    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_unpack
            assign out_field[gi] = out_frame_reg[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign out_quat_w  = out_field[0];
    assign out_quat_x  = out_field[1];
    assign out_quat_y  = out_field[2];
    assign out_quat_z  = out_field[3];
    assign out_gyro_x  = out_field[4];
    assign out_gyro_y  = out_field[5];
    assign out_gyro_z  = out_field[6];
    assign out_valid   = out_valid_reg;
    assign out_seq     = out_seq_reg;
    assign overrun_cnt = overrun_reg;
    assign stale       = (stale_cnt_reg == STALE_W'(STALE_CYCLES));

endmodule
